layer_sequencer: RTL and testbench

Command-driven controller that runs one dense-layer pass on the 2x2 TPU datapath: unified buffer, systolic array and VPU. It accepts a layer descriptor from the host and issues, in order: the weight read, the weight switch, the input and bias reads, and the result write address. It then counts VPU output beats and reports completion. It replaces the host driving those strobes by hand.

---
 rtl/layer_sequencer_if.sv | 54 +++++
 rtl/layer_sequencer.sv | 124 ++++++++++++
 tb/tb_layer_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - host descriptor, unified buffer, systolic and VPU signals of layer_sequencer
// master is the sequencer side; slave is the host/datapath side.
interface layer_sequencer_if;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [5:0] cmd_input_addr_in;
  logic [5:0] cmd_weight_addr_in;
  logic [5:0] cmd_bias_addr_in;
  logic [5:0] cmd_out_addr_in;
  logic [5:0] cmd_rows_in;
  logic [3:0] cmd_pathway_in;

  logic       ub_rd_weight_start_out;
  logic       ub_rd_weight_transpose_out;
  logic [5:0] ub_rd_weight_addr_out;
  logic [5:0] ub_rd_weight_loc_out;
  logic       ub_rd_input_start_out;
  logic       ub_rd_input_transpose_out;
  logic [5:0] ub_rd_input_addr_out;
  logic [5:0] ub_rd_input_loc_out;
  logic       ub_rd_bias_start_out;
  logic [5:0] ub_rd_bias_addr_out;
  logic [5:0] ub_rd_bias_loc_out;
  logic [5:0] ub_wr_addr_out;
  logic       ub_wr_addr_valid_out;
  logic       sys_switch_out;
  logic [3:0] vpu_data_pathway_out;
  logic       vpu_valid_in_2;
  logic       busy_out;
  logic       done_out;
  logic       error_out;

  modport master (
    input  cmd_valid_in, cmd_input_addr_in, cmd_weight_addr_in, cmd_bias_addr_in,
           cmd_out_addr_in, cmd_rows_in, cmd_pathway_in, vpu_valid_in_2,
    output cmd_ready_out,
           ub_rd_weight_start_out, ub_rd_weight_transpose_out, ub_rd_weight_addr_out, ub_rd_weight_loc_out,
           ub_rd_input_start_out, ub_rd_input_transpose_out, ub_rd_input_addr_out, ub_rd_input_loc_out,
           ub_rd_bias_start_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out,
           ub_wr_addr_out, ub_wr_addr_valid_out, sys_switch_out, vpu_data_pathway_out,
           busy_out, done_out, error_out
  );

  modport slave (
    output cmd_valid_in, cmd_input_addr_in, cmd_weight_addr_in, cmd_bias_addr_in,
           cmd_out_addr_in, cmd_rows_in, cmd_pathway_in, vpu_valid_in_2,
    input  cmd_ready_out,
           ub_rd_weight_start_out, ub_rd_weight_transpose_out, ub_rd_weight_addr_out, ub_rd_weight_loc_out,
           ub_rd_input_start_out, ub_rd_input_transpose_out, ub_rd_input_addr_out, ub_rd_input_loc_out,
           ub_rd_bias_start_out, ub_rd_bias_addr_out, ub_rd_bias_loc_out,
           ub_wr_addr_out, ub_wr_addr_valid_out, sys_switch_out, vpu_data_pathway_out,
           busy_out, done_out, error_out
  );
endinterface

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - dense-layer pass sequencer for the 2x2 TPU datapath
// Issues weight read, weight switch, input/bias reads and result address, then counts VPU beats.
module layer_sequencer #(
  parameter int W_LOAD_CYCLES = 3,
  parameter int DRAIN_TIMEOUT = 63,
  parameter bit W_TRANSPOSE   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  layer_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_SWITCH, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(W_LOAD_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(DRAIN_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_input_addr;
  logic [5:0] r_weight_addr;
  logic [5:0] r_bias_addr;
  logic [5:0] r_out_addr;
  logic [5:0] r_rows;
  logic [3:0] r_pathway;
  logic [3:0] r_wait_cnt;
  logic [5:0] r_beat_cnt;
  logic [7:0] r_tmo_cnt;
  logic       r_error;

  logic w_accept;
  logic w_active;
  logic w_wait_last;
  logic w_beat_last;
  logic w_tmo_last;
  logic w_switch;

  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid_in;
  assign w_active    = (r_state != S_IDLE);
  assign w_switch    = (r_state == S_SWITCH);
  assign w_wait_last = (r_wait_cnt == WAIT_LAST);
  assign w_beat_last = (r_beat_cnt == r_rows - 6'd1);
  assign w_tmo_last  = (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.cmd_valid_in) w_next = (bus.cmd_rows_in == 6'd0) ? S_DONE : S_WEIGHT;
      S_WEIGHT: if (w_wait_last) w_next = S_SWITCH;
      S_SWITCH: w_next = S_DRAIN;
      S_DRAIN: begin
        // A beat in the same cycle as the last idle tick wins over the timeout.
        if (bus.vpu_valid_in_2) begin
          if (w_beat_last) w_next = S_DONE;
        end else if (w_tmo_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_input_addr  <= 6'd0;
      r_weight_addr <= 6'd0;
      r_bias_addr   <= 6'd0;
      r_out_addr    <= 6'd0;
      r_rows        <= 6'd0;
      r_pathway     <= 4'd0;
      r_wait_cnt    <= 4'd0;
      r_beat_cnt    <= 6'd0;
      r_tmo_cnt     <= 8'd0;
      r_error       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_input_addr  <= bus.cmd_input_addr_in;
        r_weight_addr <= bus.cmd_weight_addr_in;
        r_bias_addr   <= bus.cmd_bias_addr_in;
        r_out_addr    <= bus.cmd_out_addr_in;
        r_rows        <= bus.cmd_rows_in;
        r_pathway     <= bus.cmd_pathway_in;
        r_error       <= 1'b0;
      end
      if (r_state == S_WEIGHT && !w_wait_last) r_wait_cnt <= r_wait_cnt + 4'd1;
      else r_wait_cnt <= 4'd0;
      if (w_switch) begin
        r_beat_cnt <= 6'd0;
        r_tmo_cnt  <= 8'd0;
      end else if (r_state == S_DRAIN) begin
        if (bus.vpu_valid_in_2) begin
          if (!w_beat_last) r_beat_cnt <= r_beat_cnt + 6'd1;
          r_tmo_cnt <= 8'd0;
        end else if (!w_tmo_last) begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready_out              = (r_state == S_IDLE);
  assign bus.busy_out                   = w_active;
  assign bus.done_out                   = (r_state == S_DONE);
  assign bus.error_out                  = (r_state == S_DONE) && r_error;
  assign bus.ub_rd_weight_start_out     = (r_state == S_WEIGHT) && (r_wait_cnt == 4'd0);
  assign bus.ub_rd_weight_transpose_out = W_TRANSPOSE;
  assign bus.ub_rd_weight_addr_out      = w_active ? r_weight_addr : 6'd0;
  assign bus.ub_rd_weight_loc_out       = w_active ? 6'd2 : 6'd0;
  assign bus.ub_rd_input_start_out      = w_switch;
  assign bus.ub_rd_input_transpose_out  = 1'b0;
  assign bus.ub_rd_input_addr_out       = w_active ? r_input_addr : 6'd0;
  assign bus.ub_rd_input_loc_out        = w_active ? r_rows : 6'd0;
  assign bus.ub_rd_bias_start_out       = w_switch;
  assign bus.ub_rd_bias_addr_out        = w_active ? r_bias_addr : 6'd0;
  assign bus.ub_rd_bias_loc_out         = w_active ? r_rows : 6'd0;
  assign bus.ub_wr_addr_out             = w_active ? r_out_addr : 6'd0;
  assign bus.ub_wr_addr_valid_out       = w_switch;
  assign bus.sys_switch_out             = w_switch;
  assign bus.vpu_data_pathway_out       = w_active ? r_pathway : 4'd0;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - self-checking bench for layer_sequencer
module tb_layer_sequencer;
  localparam int W     = 3;
  localparam int T     = 5;
  localparam bit WT    = 1'b1;
  localparam int SCHED = 512;

  typedef struct packed {
    logic [5:0] rows;
    logic [3:0] path;
    logic [5:0] wa;
    logic [5:0] ia;
    logic [5:0] ba;
    logic [5:0] oa;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    logic [31:0] beats;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  layer_sequencer_if bus ();

  layer_sequencer #(
    .W_LOAD_CYCLES(W),
    .DRAIN_TIMEOUT(T),
    .W_TRANSPOSE(WT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  function automatic cmd_t mk(input int rows, input int path, input int wa, input int ia, input int ba, input int oa);
    cmd_t c;
    c.rows = 6'(rows);
    c.path = 4'(path);
    c.wa   = 6'(wa);
    c.ia   = 6'(ia);
    c.ba   = 6'(ba);
    c.oa   = 6'(oa);
    return c;
  endfunction

  function automatic logic [56:0] obs_vec();
    return {bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.error_out,
            bus.ub_rd_weight_start_out, bus.ub_rd_weight_transpose_out, bus.ub_rd_weight_addr_out, bus.ub_rd_weight_loc_out,
            bus.ub_rd_input_start_out, bus.ub_rd_input_transpose_out, bus.ub_rd_input_addr_out, bus.ub_rd_input_loc_out,
            bus.ub_rd_bias_start_out, bus.ub_rd_bias_addr_out, bus.ub_rd_bias_loc_out,
            bus.ub_wr_addr_out, bus.ub_wr_addr_valid_out, bus.sys_switch_out, bus.vpu_data_pathway_out};
  endfunction

  function automatic logic [56:0] exp_vec(input bit idle, input bit done, input bit err, input bit ws, input bit sw, input cmd_t c);
    if (idle)
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, WT, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0,
              1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 4'd0};
    return {1'b0, 1'b1, done, err, ws, WT, c.wa, 6'd2, sw, 1'b0, c.ia, c.rows,
            sw, c.ba, c.rows, c.oa, sw, sw, c.path};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input cmd_t c);
    bus.cmd_rows_in        = c.rows;
    bus.cmd_pathway_in     = c.path;
    bus.cmd_weight_addr_in = c.wa;
    bus.cmd_input_addr_in  = c.ia;
    bus.cmd_bias_addr_in   = c.ba;
    bus.cmd_out_addr_in    = c.oa;
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    while (!bus.cmd_ready_out && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", 64'(bus.cmd_ready_out), 64'(1));
  endtask

  // Expected completion comes from the gap rule: each beat must arrive within T cycles of the
  // previous beat (or of DRAIN entry); the N-th such beat ends the pass, otherwise T idle cycles do.
  task automatic run_cmd(input cmd_t c, input logic [SCHED-1:0] sched, input bit hold, input cmd_t nxt,
                         output int obs_done, output bit obs_err, output int waited);
    int dn;
    int prev;
    int cnt;
    bit terr;
    wait_ready(waited);
    drive(c);
    bus.cmd_valid_in = 1'b1;
    @(posedge clk);
    #1;
    if (hold) drive(nxt);
    else begin
      bus.cmd_valid_in = 1'b0;
      drive(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
    end
    terr = 1'b0;
    if (c.rows == 6'd0) dn = 1;
    else begin
      prev = W + 1;
      cnt  = 0;
      dn   = 0;
      for (int k = W + 2; k < SCHED; k++) begin
        if (dn == 0 && k - prev <= T && sched[k]) begin
          cnt++;
          prev = k;
          if (cnt == int'(c.rows)) dn = k + 1;
        end
      end
      if (dn == 0) begin
        dn   = prev + T + 1;
        terr = 1'b1;
      end
    end
    obs_done = -1;
    obs_err  = 1'b0;
    for (int k = 1; k <= dn + 1; k++) begin
      bus.vpu_valid_in_2 = sched[k];
      @(negedge clk);
      if (bus.done_out && obs_done < 0) begin
        obs_done = k;
        obs_err  = bus.error_out;
      end
      chk($sformatf("cyc%0d_rows%0d", k, c.rows), 64'(obs_vec()),
          64'(exp_vec(k > dn, k == dn, (k == dn) && terr, (c.rows != 6'd0) && (k == 1),
                      (c.rows != 6'd0) && (k == W + 1), c)));
      if (k <= dn) begin
        @(posedge clk);
        #1;
      end
    end
    bus.vpu_valid_in_2 = 1'b0;
  endtask

  vec_t            tbl[9];
  cmd_t            c;
  cmd_t            n;
  cmd_t            nxt_saved;
  logic [SCHED-1:0] s;
  int              od;
  bit              oe;
  int              w;
  int              thr;
  bit              hold;
  bit              have_next;

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{mk(4, 4'b1100, 8, 0, 12, 20), 32'h0000_01E0, 9, 1'b0};
    tbl[1] = '{mk(0, 4'b0011, 1, 2, 3, 4), 32'h0000_0000, 1, 1'b0};
    tbl[2] = '{mk(2, 4'b0110, 5, 6, 7, 9), 32'h0000_0020, 11, 1'b1};
    tbl[3] = '{mk(3, 4'b1001, 10, 11, 12, 13), 32'h0000_0000, 10, 1'b1};
    tbl[4] = '{mk(1, 4'b0001, 14, 15, 16, 17), 32'h0000_0200, 10, 1'b0};
    tbl[5] = '{mk(2, 4'b0010, 18, 19, 21, 22), 32'h0000_0820, 11, 1'b1};
    tbl[6] = '{mk(2, 4'b0100, 23, 24, 25, 26), 32'h0000_0420, 11, 1'b0};
    tbl[7] = '{mk(1, 4'b1000, 27, 28, 29, 30), 32'h0000_004C, 7, 1'b0};
    tbl[8] = '{mk(2, 4'b1111, 63, 63, 63, 63), 32'h0000_0060, 7, 1'b0};

    rst = 1'b1;
    bus.cmd_valid_in   = 1'b0;
    bus.vpu_valid_in_2 = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_during", 64'(obs_vec()), 64'(exp_vec(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0))));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_after", 64'(obs_vec()), 64'(exp_vec(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0))));

    foreach (tbl[i]) begin
      run_cmd(tbl[i].c, SCHED'(tbl[i].beats), 1'b0, tbl[i].c, od, oe, w);
      chk($sformatf("tbl%0d_done_cycle", i), 64'(od), 64'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_error", i), 64'(oe), 64'(tbl[i].exp_err));
    end

    c = mk(3, 4'b0111, 2, 4, 6, 8);
    wait_ready(w);
    drive(c);
    bus.cmd_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.vpu_valid_in_2 = (k == 5);
      @(negedge clk);
      if (k == 6) chk("drain_before_rst", 64'(obs_vec()), 64'(exp_vec(0, 0, 0, 0, 0, c)));
      else begin
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b1;
    bus.vpu_valid_in_2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.vpu_valid_in_2 = 1'b1;
      @(negedge clk);
      chk($sformatf("rst_abort_idle%0d", k), 64'(obs_vec()), 64'(exp_vec(1, 0, 0, 0, 0, c)));
      @(posedge clk);
      #1;
    end
    bus.vpu_valid_in_2 = 1'b0;
    run_cmd(tbl[0].c, SCHED'(tbl[0].beats), 1'b0, tbl[0].c, od, oe, w);
    chk("after_rst_done_cycle", 64'(od), 64'(9));

    c = mk(2, 4'b1010, 3, 5, 7, 11);
    n = mk(1, 4'b0101, 13, 17, 19, 23);
    run_cmd(c, {SCHED{1'b1}}, 1'b1, n, od, oe, w);
    chk("b2b_first_done", 64'(od), 64'(7));
    run_cmd(n, {SCHED{1'b1}}, 1'b0, n, od, oe, w);
    chk("b2b_accept_wait", 64'(w), 64'(0));
    chk("b2b_second_done", 64'(od), 64'(6));

    have_next = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (have_next) c = nxt_saved;
      else begin
        c = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom);
        if ($urandom_range(0, 4) == 0) c.rows = 6'($urandom_range(0, 63));
      end
      thr = $urandom_range(1, 3);
      for (int k = 0; k < SCHED; k++) s[k] = ($urandom_range(0, 3) < thr);
      hold = ($urandom_range(0, 3) == 0) && (r < 39);
      n = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom);
      run_cmd(c, s, hold, n, od, oe, w);
      if (have_next) chk($sformatf("rand%0d_b2b_wait", r), 64'(w), 64'(0));
      have_next = hold;
      nxt_saved = n;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
